// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline control for the 5-stage LEGv8 core. Owns the IF/ID register
//   (instruction, PC, valid) with stall and flush. Tracks the register usage
//   of every instruction through ID/EX, EX/MEM and MEM/WB. From that state it
//   produces load-use stalls, EX-stage forwarding selects and branch flushes.
//
// Ports
//   clk, reset                 core clock, synchronous active-high reset
//   if_instr, if_pc            fetched instruction and its PC
//   id_instr, id_pc, id_valid  IF/ID register contents
//   id_reg2loc .. id_memRead   controller decode of the instruction in ID
//   br_taken                   branch resolved taken in MEM
//   pc_write                   PC register enable
//   idex_bubble                zero ID/EX controls this edge (stall)
//   flush                      zero ID/EX and EX/MEM controls this edge
//   fwdA, fwdB                 EX operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
module pipe_hazard_ctrl #(
    parameter int          N        = 64,
    parameter int          RA       = 5,
    parameter int          ZERO_REG = 31,
    parameter logic [31:0] NOP_WORD = 32'h00000000,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  if_instr,
    input  logic [N-1:0] if_pc,
    output logic [31:0]  id_instr,
    output logic [N-1:0] id_pc,
    output logic         id_valid,
    input  logic         id_reg2loc,
    input  logic         id_uses_rn,
    input  logic         id_uses_r2,
    input  logic         id_regWrite,
    input  logic         id_memRead,
    input  logic         br_taken,
    output logic         pc_write,
    output logic         idex_bubble,
    output logic         flush,
    output logic [1:0]   fwdA,
    output logic [1:0]   fwdB
);

    localparam logic [RA-1:0] ZR = ZERO_REG[RA-1:0];

    // Register usage of one in-flight instruction.
    typedef struct packed {
        logic          valid;
        logic          rw;
        logic          mr;
        logic [RA-1:0] rd;
        logic [RA-1:0] rn;
        logic [RA-1:0] r2;
        logic          urn;
        logic          ur2;
    } stg_t;

    logic [31:0]  id_instr_q, id_instr_d;
    logic [N-1:0] id_pc_q,    id_pc_d;
    logic         id_valid_q, id_valid_d;
    stg_t         idex_q, idex_d;
    stg_t         exmem_q, exmem_d;
    stg_t         memwb_q, memwb_d;
    stg_t         id_stg;
    logic         hit_ex, hit_mem, stall;

    // Producer stage s writes the source register src that a consumer reads.
    function automatic logic hit(input stg_t s, input logic [RA-1:0] src,
                                 input logic uses);
        return s.valid && s.rw && (s.rd == src) && (s.rd != ZR) && uses;
    endfunction

    // Decode of the instruction sitting in ID. An invalid IF/ID entry yields
    // an invalid stage record, which both disables the ID-side hazard checks
    // and enters ID/EX as a bubble.
    always_comb begin
        id_stg       = '0;
        id_stg.valid = id_valid_q;
        id_stg.rw    = id_regWrite;
        id_stg.mr    = id_memRead;
        id_stg.rd    = id_instr_q[RA-1:0];
        id_stg.rn    = id_instr_q[5 +: RA];
        id_stg.r2    = id_reg2loc ? id_instr_q[RA-1:0] : id_instr_q[16 +: RA];
        id_stg.urn   = id_uses_rn;
        id_stg.ur2   = id_uses_r2;
    end

    assign hit_ex  = hit(idex_q,  id_stg.rn, id_stg.urn) | hit(idex_q,  id_stg.r2, id_stg.ur2);
    assign hit_mem = hit(exmem_q, id_stg.rn, id_stg.urn) | hit(exmem_q, id_stg.r2, id_stg.ur2);

    // With forwarding only a load in EX cannot be bypassed. Without it, every
    // producer still in EX or MEM must drain first. MEM/WB never stalls
    // because the register file writes through.
    always_comb begin
        stall = 1'b0;
        if (!reset && id_valid_q) begin
            if (FWD_EN) stall = idex_q.mr && hit_ex;
            else        stall = hit_ex || hit_mem;
        end
    end

    assign flush       = br_taken && !reset;
    assign pc_write    = flush || !stall;
    assign idex_bubble = stall && !flush;

    always_comb begin
        id_instr_d = if_instr;
        id_pc_d    = if_pc;
        id_valid_d = 1'b1;
        idex_d     = id_stg;
        exmem_d    = idex_q;
        memwb_d    = exmem_q;
        if (br_taken) begin
            // Wrong-path instructions in ID, EX and MEM entry are dropped.
            // The branch itself (leaving EX/MEM) still retires.
            id_instr_d = NOP_WORD;
            id_pc_d    = id_pc_q;
            id_valid_d = 1'b0;
            idex_d     = '0;
            exmem_d    = '0;
        end else if (stall) begin
            id_instr_d = id_instr_q;
            id_pc_d    = id_pc_q;
            id_valid_d = id_valid_q;
            idex_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_instr_q <= NOP_WORD;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
            idex_q     <= '0;
            exmem_q    <= '0;
            memwb_q    <= '0;
        end else begin
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            idex_q     <= idex_d;
            exmem_q    <= exmem_d;
            memwb_q    <= memwb_d;
        end
    end

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (FWD_EN && !reset && idex_q.valid) begin
            if      (hit(exmem_q, idex_q.rn, idex_q.urn)) fwdA = 2'b10;
            else if (hit(memwb_q, idex_q.rn, idex_q.urn)) fwdA = 2'b01;
            if      (hit(exmem_q, idex_q.r2, idex_q.ur2)) fwdB = 2'b10;
            else if (hit(memwb_q, idex_q.r2, idex_q.ur2)) fwdB = 2'b01;
        end
    end

    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_valid = id_valid_q;

    // Opcode bits and a few tracked fields are not needed by the hazard logic.
    logic unused_bits;
    assign unused_bits = ^{id_instr_q, exmem_q, memwb_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one forwarding build (u1) and one
// stall-only build (u2), each fed its own instruction stream.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [31:0] ifi1, ifi2, idi1, idi2;
    logic [63:0] ifp1, ifp2, idp1, idp2;
    logic        idv1, idv2, br1, br2;
    logic        r2l1, urn1, ur21, rw1, mr1;
    logic        r2l2, urn2, ur22, rw2, mr2;
    logic        pw1, bub1, fl1, pw2, bub2, fl2;
    logic [1:0]  fa1, fb1, fa2, fb2;

    int cmp = 0;
    int mis = 0;

    // Controller stand-in: {reg2loc, uses_rn, uses_r2, regWrite, memRead}
    function automatic logic [4:0] dec(input logic [31:0] w);
        case (w[31:21])
            11'h458, 11'h658: return 5'b01110;
            11'h7C2:          return 5'b01011;
            default:          return 5'b00000;
        endcase
    endfunction

    assign {r2l1, urn1, ur21, rw1, mr1} = dec(idi1);
    assign {r2l2, urn2, ur22, rw2, mr2} = dec(idi2);

    function automatic logic [31:0] add_i(input logic [4:0] rd, rn, rm);
        return {11'h458, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] sub_i(input logic [4:0] rd, rn, rm);
        return {11'h658, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] ldur_i(input logic [4:0] rt, rn);
        return {11'h7C2, 9'd0, 2'b00, rn, rt};
    endfunction

    pipe_hazard_ctrl #(.N(64), .RA(5), .ZERO_REG(31), .NOP_WORD(32'h0), .FWD_EN(1'b1)) u1 (
        .clk(clk), .reset(reset), .if_instr(ifi1), .if_pc(ifp1),
        .id_instr(idi1), .id_pc(idp1), .id_valid(idv1),
        .id_reg2loc(r2l1), .id_uses_rn(urn1), .id_uses_r2(ur21),
        .id_regWrite(rw1), .id_memRead(mr1), .br_taken(br1),
        .pc_write(pw1), .idex_bubble(bub1), .flush(fl1), .fwdA(fa1), .fwdB(fb1));

    pipe_hazard_ctrl #(.N(64), .RA(5), .ZERO_REG(31), .NOP_WORD(32'h0), .FWD_EN(1'b0)) u2 (
        .clk(clk), .reset(reset), .if_instr(ifi2), .if_pc(ifp2),
        .id_instr(idi2), .id_pc(idp2), .id_valid(idv2),
        .id_reg2loc(r2l2), .id_uses_rn(urn2), .id_uses_r2(ur22),
        .id_regWrite(rw2), .id_memRead(mr2), .br_taken(br2),
        .pc_write(pw2), .idex_bubble(bub2), .flush(fl2), .fwdA(fa2), .fwdB(fb2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed1(input logic [31:0] w);
        ifi1 = w;
        ifp1 = ifp1 + 64'd4;
        tick();
    endtask

    task automatic feed2(input logic [31:0] w);
        ifi2 = w;
        ifp2 = ifp2 + 64'd4;
        tick();
    endtask

    task automatic drain1();
        for (int i = 0; i < 4; i++) feed1(32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifi1  = 32'hDEADBEEF;
        ifp1  = 64'h40;
        tick();
        cmp++; if (idi1 !== 32'h0) begin mis++; $display("FAIL rst_instr got=%h exp=%h", idi1, 32'h0); end
        cmp++; if (idv1 !== 1'b0) begin mis++; $display("FAIL rst_valid got=%b exp=0", idv1); end
        cmp++; if (idp1 !== 64'h0) begin mis++; $display("FAIL rst_pc got=%h exp=0", idp1); end
        cmp++; if ({pw1, bub1, fl1} !== 3'b100) begin mis++; $display("FAIL rst_ctl got=%b exp=100", {pw1, bub1, fl1}); end
        cmp++; if ({fa1, fb1} !== 4'b0000) begin mis++; $display("FAIL rst_fwd got=%b exp=0000", {fa1, fb1}); end
        ifi1 = 32'h12345678;
        tick();
        cmp++; if (idi1 !== 32'h0) begin mis++; $display("FAIL rst_hold got=%h exp=%h", idi1, 32'h0); end
        reset = 1'b0;
        ifi1  = 32'hF84003E1;
        ifp1  = 64'h100;
        tick();
        cmp++; if (idi1 !== 32'hF84003E1) begin mis++; $display("FAIL first_instr got=%h exp=F84003E1", idi1); end
        cmp++; if (idv1 !== 1'b1 || idp1 !== 64'h100) begin mis++; $display("FAIL first_vld_pc got=%b/%h exp=1/100", idv1, idp1); end
    endtask

    task automatic test_ex_forward();
        drain1();
        feed1(add_i(1, 2, 3));
        feed1(sub_i(4, 1, 5));
        cmp++; if ({pw1, bub1} !== 2'b10) begin mis++; $display("FAIL exfwd_nostall got=%b exp=10", {pw1, bub1}); end
        feed1(32'h0);
        cmp++; if (fa1 !== 2'b10) begin mis++; $display("FAIL exfwd_A got=%b exp=10", fa1); end
        cmp++; if (fb1 !== 2'b00) begin mis++; $display("FAIL exfwd_B got=%b exp=00", fb1); end
        drain1();
        feed1(add_i(1, 2, 3));
        feed1(add_i(6, 7, 8));
        feed1(sub_i(4, 1, 5));
        feed1(32'h0);
        cmp++; if (fa1 !== 2'b01) begin mis++; $display("FAIL memfwd_A got=%b exp=01", fa1); end
    endtask

    task automatic test_double_hazard();
        drain1();
        feed1(add_i(1, 2, 3));
        feed1(add_i(1, 6, 7));
        feed1(sub_i(4, 1, 1));
        feed1(32'h0);
        cmp++; if ({fa1, fb1} !== 4'b1010) begin mis++; $display("FAIL dbl_fwd got=%b exp=1010", {fa1, fb1}); end
    endtask

    task automatic test_load_use();
        drain1();
        feed1(ldur_i(1, 2));
        feed1(add_i(3, 1, 4));
        ifi1 = add_i(9, 10, 11);
        #1;
        cmp++; if ({pw1, bub1, fl1} !== 3'b010) begin mis++; $display("FAIL lu_stall got=%b exp=010", {pw1, bub1, fl1}); end
        tick();
        cmp++; if (idi1 !== add_i(3, 1, 4)) begin mis++; $display("FAIL lu_hold got=%h exp=%h", idi1, add_i(3, 1, 4)); end
        cmp++; if ({pw1, bub1} !== 2'b10) begin mis++; $display("FAIL lu_once got=%b exp=10", {pw1, bub1}); end
        tick();
        cmp++; if (fa1 !== 2'b01) begin mis++; $display("FAIL lu_fwdA got=%b exp=01", fa1); end
        drain1();
        feed1(ldur_i(31, 2));
        feed1(add_i(3, 31, 4));
        cmp++; if ({pw1, bub1} !== 2'b10) begin mis++; $display("FAIL xzr_nostall got=%b exp=10", {pw1, bub1}); end
        feed1(32'h0);
        cmp++; if (fa1 !== 2'b00) begin mis++; $display("FAIL xzr_fwd got=%b exp=00", fa1); end
    endtask

    task automatic test_branch_flush();
        drain1();
        feed1(add_i(1, 2, 3));
        feed1(ldur_i(6, 2));
        feed1(add_i(7, 6, 8));
        br1 = 1'b1;
        #1;
        cmp++; if ({pw1, bub1, fl1} !== 3'b101) begin mis++; $display("FAIL br_ctl got=%b exp=101", {pw1, bub1, fl1}); end
        tick();
        br1 = 1'b0;
        #1;
        cmp++; if (idv1 !== 1'b0 || idi1 !== 32'h0) begin mis++; $display("FAIL br_ifid got=%b/%h exp=0/0", idv1, idi1); end
        cmp++; if ({pw1, fl1} !== 2'b10) begin mis++; $display("FAIL br_after got=%b exp=10", {pw1, fl1}); end
        feed1(sub_i(4, 1, 6));
        feed1(32'h0);
        cmp++; if ({fa1, fb1} !== 4'b0000) begin mis++; $display("FAIL br_nofwd got=%b exp=0000", {fa1, fb1}); end
    endtask

    task automatic test_stall_mode();
        feed2(add_i(1, 2, 3));
        feed2(sub_i(4, 1, 5));
        ifi2 = 32'h0;
        #1;
        cmp++; if ({pw2, bub2, fa2} !== 4'b0100) begin mis++; $display("FAIL nf_stall1 got=%b exp=0100", {pw2, bub2, fa2}); end
        tick();
        cmp++; if ({pw2, bub2, fa2} !== 4'b0100) begin mis++; $display("FAIL nf_stall2 got=%b exp=0100", {pw2, bub2, fa2}); end
        cmp++; if (idi2 !== sub_i(4, 1, 5)) begin mis++; $display("FAIL nf_hold got=%h exp=%h", idi2, sub_i(4, 1, 5)); end
        tick();
        cmp++; if ({pw2, bub2} !== 2'b10) begin mis++; $display("FAIL nf_go got=%b exp=10", {pw2, bub2}); end
        tick();
        cmp++; if ({fa2, fb2} !== 4'b0000) begin mis++; $display("FAIL nf_fwd got=%b exp=0000", {fa2, fb2}); end
    endtask

    initial begin
        reset = 1'b1;
        ifi1 = 32'h0; ifp1 = 64'h0; br1 = 1'b0;
        ifi2 = 32'h0; ifp2 = 64'h0; br2 = 1'b0;
        test_reset();
        test_ex_forward();
        test_double_hazard();
        test_load_use();
        test_branch_flush();
        test_stall_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control for the 5-stage LEGv8 core: owns the IF/ID instruction/PC register with stall and flush, and tracks destination and source registers through ID/EX, EX/MEM and MEM/WB.
- Generates load-use stalls, EX-stage forwarding selects and branch flushes.
- Generalises the fixed 11-bit, always-enabled IF/ID flop to full-width, parametrised, stall/flush-capable control with a selectable forward-or-stall mode.
- Sits between imem/PC logic, controller and datapath.

Parameters:
N, 64, PC/data width
RA, 5, register address width
ZERO_REG, 31, hard-wired zero register (XZR); never a hazard source or destination
NOP_WORD, 32'h00000000, instruction word injected into IF/ID on flush
FWD_EN, 1, 1 = forward RAW hazards; 0 = resolve every RAW hazard by stalling

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
if_instr  in  32  instruction word from imem
if_pc  in  N  PC of if_instr
id_instr  out  32  IF/ID registered instruction
id_pc  out  N  IF/ID registered PC
id_valid  out  1  IF/ID holds a real instruction
id_reg2loc  in  1  controller: second source is instr[4:0] (1) or instr[20:16] (0)
id_uses_rn  in  1  ID instruction reads Rn = instr[9:5]
id_uses_r2  in  1  ID instruction reads the second source
id_regWrite  in  1  ID instruction writes Rd = instr[4:0]
id_memRead  in  1  ID instruction is a load
br_taken  in  1  branch resolved taken in MEM stage
pc_write  out  1  PC register enable
idex_bubble  out  1  datapath must zero ID/EX control signals this edge
flush  out  1  datapath must zero ID/EX and EX/MEM control signals this edge
fwdA  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwdB  out  2  EX operand B select, same encoding

Behaviour:
- Reset (synchronous; overrides all other inputs):
  - id_instr = NOP_WORD, id_pc = 0, id_valid = 0.
  - All tracked stages invalid; fwdA = fwdB = 00.
  - pc_write = 1, idex_bubble = 0, flush = 0.
- Tracking:
  - Each stage register (ID/EX, EX/MEM, MEM/WB) holds valid, regWrite, memRead, rd, rn, r2, uses_rn, uses_r2.
  - Captured from ID decode; advances one stage per clock; never stalls past ID.
- Hazard match: a source register matches a stage when
  - the stage is valid with regWrite = 1, and
  - stage rd equals the source, and rd != ZERO_REG, and
  - the corresponding uses_* bit is set.
- Load-use (FWD_EN = 1): ID/EX is a valid load and matches an ID source -> stall.
- Stall mode (FWD_EN = 0): any match in ID/EX or EX/MEM -> stall.
  - The register file is write-through, so MEM/WB never stalls.
- Stall, 1 cycle per evaluation, re-evaluated every cycle:
  - pc_write = 0.
  - IF/ID holds id_instr, id_pc and id_valid.
  - idex_bubble = 1; ID/EX tracking becomes invalid.
- Forwarding (combinational from registered state; forced 00 when FWD_EN = 0):
  - fwdA = 10 if EX/MEM matches ID/EX rn; else 01 if MEM/WB matches; else 00. fwdB identical using r2.
  - EX/MEM has priority over MEM/WB when both match.
- br_taken (priority over stall in the same cycle):
  - flush = 1, pc_write = 1.
  - IF/ID loads NOP_WORD with id_valid = 0.
  - ID/EX and EX/MEM tracking become invalid; MEM/WB advances normally.
  - idex_bubble = 0.
- Normal cycle: IF/ID loads if_instr/if_pc with id_valid = 1; pc_write = 1.
- id_valid = 0 suppresses all ID-side hazard checks.
- Latency: IF/ID is 1 cycle; stall and flush outputs are combinational in the same cycle as their cause.

Test Plan:
- Reset: hold reset 2 cycles with arbitrary if_instr -> id_instr = 0, id_valid = 0, pc_write = 1, fwdA = fwdB = 00; first if_instr 0xF84003E1 after release appears on id_instr one cycle later.
- EX forward: ADD X1,X2,X3 then SUB X4,X1,X5 (FWD_EN = 1) -> SUB in EX gives fwdA = 10, no stall. With one independent instruction between them -> fwdA = 01.
- Double hazard: ADD X1; ADD X1; SUB X4,X1,X1 -> fwdA = fwdB = 10 (EX/MEM priority).
- Load-use: LDUR X1,[X2,#0] then ADD X3,X1,X4 -> exactly one cycle of pc_write = 0 and idex_bubble = 1 with id_instr held; next cycle fwdA = 01. Destination X31 instead -> no stall.
- Branch flush: br_taken = 1 in the same cycle a load-use stall is detected -> flush = 1, pc_write = 1, idex_bubble = 0, id_valid = 0 next cycle, no forward from flushed stages.
- FWD_EN = 0 build: ADD X1 then SUB X4,X1,X5 -> two stall cycles, fwdA = 00 throughout, SUB proceeds on the third cycle.
